// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - data-memory map, MMIO offsets, STATUS bits and address decode
package mem_map_pkg;

   localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
   localparam logic [31:0] A_GPIO_OUT = MMIO_BASE + 32'h00;
   localparam logic [31:0] A_GPIO_IN  = MMIO_BASE + 32'h04;
   localparam logic [31:0] A_CYCLE    = MMIO_BASE + 32'h08;
   localparam logic [31:0] A_TX_DATA  = MMIO_BASE + 32'h0C;
   localparam logic [31:0] A_STATUS   = MMIO_BASE + 32'h10;

   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_BUS_ERR = 3;
   localparam int ST_CNT_LSB = 8;

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_GPIO_OUT,
      SEL_GPIO_IN,
      SEL_CYCLE,
      SEL_TX_DATA,
      SEL_STATUS,
      SEL_BAD
   } sel_e;

   // Byte lane bits are dropped before the compare: word access only.
   function automatic sel_e decode(input logic [31:0] addr);
      logic [31:0] word;
      word = {addr[31:2], 2'b00};
      if (!addr[31]) return SEL_RAM;
      case (word)
         A_GPIO_OUT: return SEL_GPIO_OUT;
         A_GPIO_IN:  return SEL_GPIO_IN;
         A_CYCLE:    return SEL_CYCLE;
         A_TX_DATA:  return SEL_TX_DATA;
         A_STATUS:   return SEL_STATUS;
         default:    return SEL_BAD;
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead circular FIFO with count, push accepted when full if popping
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_pop;
   logic             w_push;

   assign empty  = (r_count == '0);
   assign full   = (r_count == (AW+1)'(DEPTH));
   assign count  = r_count;
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);
   // Empty reads as zero so the head is clean right after reset.
   assign dout   = empty ? '0 : r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push && !reset) r_mem[r_wptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU data-memory responder: word RAM, GPIO, cycle counter, TX FIFO
module data_mem_responder
   import mem_map_pkg::*;
#(
   parameter int    RAM_WORDS  = 1024,
   parameter string INIT_FILE  = "",
   parameter int    FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_write,
   output logic [31:0] mem_rdata,
   output logic [31:0] gpio_out,
   input  logic [31:0] gpio_in,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int RAW = $clog2(RAM_WORDS);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]    r_ram [RAM_WORDS];
   logic [31:0]    r_rdata;
   logic [31:0]    r_gpio_out;
   logic [31:0]    r_gpio_s1;
   logic [31:0]    r_gpio_s2;
   logic [31:0]    r_cycle;
   logic           r_ovf;
   logic           r_bus_err;

   sel_e           w_sel;
   logic [RAW-1:0] w_idx;
   logic [31:0]    w_rd;
   logic [31:0]    w_status;
   logic           w_full;
   logic           w_empty;
   logic [CW-1:0]  w_count;
   logic           w_push;
   logic           w_pop;
   logic           w_ovf_evt;
   logic           w_err_evt;
   logic           w_status_wr;
   logic           w_unused_lanes;

   assign w_sel          = decode(mem_addr);
   assign w_idx          = mem_addr[RAW+1:2];
   assign w_unused_lanes = ^mem_addr[1:0];
   assign w_push         = mem_write && (w_sel == SEL_TX_DATA);
   assign w_pop          = tx_valid & tx_ready;
   assign w_ovf_evt      = w_push & w_full & ~w_pop;
   assign w_err_evt      = (w_sel == SEL_BAD);
   assign w_status_wr    = mem_write && (w_sel == SEL_STATUS);
   assign tx_valid       = ~w_empty;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .din   (mem_wdata[7:0]),
      .full  (w_full),
      .pop   (w_pop),
      .dout  (tx_data),
      .empty (w_empty),
      .count (w_count)
   );

   always_comb begin
      w_status                      = '0;
      w_status[ST_FULL]             = w_full;
      w_status[ST_EMPTY]            = w_empty;
      w_status[ST_OVF]              = r_ovf;
      w_status[ST_BUS_ERR]          = r_bus_err;
      w_status[ST_CNT_LSB +: 8]     = 8'(w_count);
   end

   always_comb begin
      w_rd = '0;
      case (w_sel)
         SEL_RAM:      w_rd = r_ram[w_idx];
         SEL_GPIO_OUT: w_rd = r_gpio_out;
         SEL_GPIO_IN:  w_rd = r_gpio_s2;
         SEL_CYCLE:    w_rd = r_cycle;
         SEL_STATUS:   w_rd = w_status;
         default:      w_rd = '0;
      endcase
   end

   // Non-blocking update gives read-first behaviour on a same-address store.
   always_ff @(posedge clk) begin
      if (mem_write && (w_sel == SEL_RAM)) r_ram[w_idx] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata    <= '0;
         r_gpio_out <= '0;
         r_gpio_s1  <= '0;
         r_gpio_s2  <= '0;
         r_cycle    <= '0;
         r_ovf      <= 1'b0;
         r_bus_err  <= 1'b0;
      end else begin
         r_rdata   <= w_rd;
         r_gpio_s1 <= gpio_in;
         r_gpio_s2 <= r_gpio_s1;
         r_cycle   <= r_cycle + 32'd1;
         if (mem_write && (w_sel == SEL_GPIO_OUT)) r_gpio_out <= mem_wdata;
         r_ovf     <= (r_ovf & ~w_status_wr) | w_ovf_evt;
         r_bus_err <= (r_bus_err & ~w_status_wr) | w_err_evt;
      end
   end

   assign mem_rdata = r_rdata;
   assign gpio_out  = r_gpio_out;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

   localparam logic [31:0] A_GPIO_OUT = 32'h8000_0000;
   localparam logic [31:0] A_GPIO_IN  = 32'h8000_0004;
   localparam logic [31:0] A_CYCLE    = 32'h8000_0008;
   localparam logic [31:0] A_TX       = 32'h8000_000C;
   localparam logic [31:0] A_STATUS   = 32'h8000_0010;
   localparam logic [31:0] A_BAD      = 32'h8000_0040;

   logic        clk;
   logic        reset;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic [31:0] mem_rdata;
   logic [31:0] gpio_out;
   logic [31:0] gpio_in;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   int n_tests = 0;
   int n_fail  = 0;

   data_mem_responder dut (
      .clk       (clk),
      .reset     (reset),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata),
      .gpio_out  (gpio_out),
      .gpio_in   (gpio_in),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one access for a cycle; on return the edge has sampled it.
   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w);
      mem_addr  = a;
      mem_wdata = d;
      mem_write = w;
      step();
      mem_write = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_write = 1'b0;
      gpio_in   = '0;
      tx_ready  = 1'b0;
      bus(A_CYCLE, 0, 0);
      bus(A_CYCLE, 0, 0);
      check("rst_rdata",    mem_rdata, 32'h0);
      check("rst_gpio_out", gpio_out, 32'h0);
      check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      check("rst_tx_data",  {24'b0, tx_data}, 32'h0);

      reset = 1'b0;
      bus(A_CYCLE, 0, 0); check("cycle0", mem_rdata, 32'd0);
      bus(A_CYCLE, 0, 0); check("cycle1", mem_rdata, 32'd1);
      bus(A_CYCLE, 0, 0); check("cycle2", mem_rdata, 32'd2);
      force dut.r_cycle = 32'hFFFF_FFFF;
      #1;
      release dut.r_cycle;
      bus(A_CYCLE, 0, 0); check("cycle_max",  mem_rdata, 32'hFFFF_FFFF);
      bus(A_CYCLE, 0, 0); check("cycle_wrap", mem_rdata, 32'h0);

      bus(32'h10, 32'hDEAD_BEEF, 1);
      bus(32'h10, 0, 0);       check("ram_rt",       mem_rdata, 32'hDEAD_BEEF);
      bus(32'h10, 32'h1, 1);   check("ram_rd_first", mem_rdata, 32'hDEAD_BEEF);
      bus(32'h10, 0, 0);       check("ram_new",      mem_rdata, 32'h1);
      bus(32'h1010, 0, 0);     check("ram_alias",    mem_rdata, 32'h1);
      bus(32'h13, 0, 0);       check("ram_lanes",    mem_rdata, 32'h1);

      bus(A_GPIO_OUT, 32'h1234, 1); check("gpio_out", gpio_out, 32'h1234);
      bus(A_GPIO_OUT, 0, 0);        check("gpio_out_rd", mem_rdata, 32'h1234);
      gpio_in = 32'hA5;
      bus(A_GPIO_IN, 0, 0); check("gpio_in_c0", mem_rdata, 32'h0);
      bus(A_GPIO_IN, 0, 0); check("gpio_in_c1", mem_rdata, 32'h0);
      bus(A_GPIO_IN, 0, 0); check("gpio_in_c2", mem_rdata, 32'hA5);

      bus(A_TX, 32'h41, 1);
      bus(A_TX, 32'h42, 1);
      bus(A_TX, 32'h43, 1);
      bus(A_STATUS, 0, 0);
      check("st_cnt3",   mem_rdata, 32'h0000_0300);
      check("tx_valid3", {31'b0, tx_valid}, 32'h1);
      check("tx_head41", {24'b0, tx_data}, 32'h41);
      bus(A_STATUS, 0, 0); check("tx_hold41", {24'b0, tx_data}, 32'h41);
      tx_ready = 1'b1;
      bus(A_STATUS, 0, 0); check("tx_42", {24'b0, tx_data}, 32'h42);
      bus(A_STATUS, 0, 0); check("tx_43", {24'b0, tx_data}, 32'h43);
      bus(A_STATUS, 0, 0); check("tx_drained", {31'b0, tx_valid}, 32'h0);
      tx_ready = 1'b0;
      bus(A_STATUS, 0, 0); check("st_empty", mem_rdata, 32'h0000_0002);

      for (int i = 0; i < 8; i++) bus(A_TX, 32'h10 + i, 1);
      bus(A_TX, 32'h99, 1);
      bus(A_STATUS, 0, 0);
      check("st_ovf",     mem_rdata, 32'h0000_0805);
      check("ovf_head",   {24'b0, tx_data}, 32'h10);
      tx_ready = 1'b1;
      bus(A_TX, 32'h99, 1);
      tx_ready = 1'b0;
      bus(A_STATUS, 0, 0);
      check("st_pushpop", mem_rdata, 32'h0000_0805);
      check("pp_head",    {24'b0, tx_data}, 32'h11);
      bus(A_STATUS, 32'h0, 1);
      bus(A_STATUS, 0, 0); check("st_clr", mem_rdata, 32'h0000_0801);

      bus(A_BAD, 0, 0);    check("bad_rd",  mem_rdata, 32'h0);
      bus(A_STATUS, 0, 0); check("st_berr", mem_rdata, 32'h0000_0809);

      tx_ready = 1'b1;
      repeat (5) bus(A_STATUS, 0, 0);
      tx_ready = 1'b0;
      bus(A_STATUS, 0, 0);
      check("st_cnt3b", mem_rdata, 32'h0000_0308);
      check("head16",   {24'b0, tx_data}, 32'h16);

      reset = 1'b1;
      bus(A_GPIO_OUT, 0, 0);
      check("mid_rst_rdata", mem_rdata, 32'h0);
      check("mid_rst_valid", {31'b0, tx_valid}, 32'h0);
      check("mid_rst_gpio",  gpio_out, 32'h0);
      reset = 1'b0;
      bus(A_STATUS, 0, 0); check("st_after_rst", mem_rdata, 32'h0000_0002);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
